// File: rtl/contador_sequenciador_if.sv
// ----------------------------------------------------------------------------
// contador_sequenciador_if
// Request bus between the requesters and the counter sequencer.
//   req_valid : one request-pending bit per requester
//   req_dir   : step direction per requester (1 = up, 0 = down)
//   req_qtd   : step count per requester, requester i at [i*QTD_W +: QTD_W]
//   req_ready : one-hot accept strobe back to the requesters
// master = requester side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface contador_sequenciador_if #(
  parameter int N_REQ = 4,
  parameter int QTD_W = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_dir;
  logic [N_REQ*QTD_W-1:0] req_qtd;
  logic [N_REQ-1:0]       req_ready;

  modport master (output req_valid, output req_dir, output req_qtd, input req_ready);
  modport slave  (input req_valid, input req_dir, input req_qtd, output req_ready);
endinterface

// File: rtl/contador_sequenciador.sv
// ----------------------------------------------------------------------------
// contador_sequenciador
// Shares an 8-bit up/down counter between N_REQ requesters. A round-robin
// winner is accepted, then its burst is played out as one increment or
// decrement strobe per cycle. A shadow of the counter value is kept so the
// burst stops at VAL_MIN/VAL_MAX instead of wrapping.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   req               : request bus (slave modport)
//   acrescer/decrecer : registered strobes to the counter
//   ocupado           : burst in progress
//   id_ativo          : index of the granted requester
//   fim, saturou      : end-of-burst pulse and its saturation flag
//   valor             : shadow of the counter value
// ----------------------------------------------------------------------------
module contador_sequenciador #(
  parameter int         N_REQ     = 4,
  parameter int         QTD_W     = 4,
  parameter logic [7:0] VAL_RESET = 8'h6A,
  parameter logic [7:0] VAL_MIN   = 8'h00,
  parameter logic [7:0] VAL_MAX   = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  contador_sequenciador_if.slave  req,
  output logic                    acrescer,
  output logic                    decrecer,
  output logic                    ocupado,
  output logic [2:0]              id_ativo,
  output logic                    fim,
  output logic                    saturou,
  output logic [7:0]              valor
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIM  = 2'd2;

  localparam logic [QTD_W-1:0] QTD_ZERO = {QTD_W{1'b0}};
  localparam logic [QTD_W-1:0] QTD_ONE  = {{(QTD_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r, state_s;
  logic [QTD_W-1:0] rem_r, rem_s;
  logic             dir_r, dir_s;
  logic             sat_r, sat_s;
  logic [7:0]       valor_r, valor_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [2:0]       id_r, id_s;
  logic             ocup_r, ocup_s;
  logic             acr_r, acr_s;
  logic             dec_r, dec_s;
  logic             fim_r, fim_s;
  logic             satout_r, satout_s;

  logic [3:0]       pick_s;
  logic             hit_s;
  logic [2:0]       win_s;
  logic             win_dir_s;
  logic [QTD_W-1:0] win_qtd_s;
  logic             accept_s;
  logic [N_REQ-1:0] ready_s;

  // True when a step in direction d from v would leave the allowed range.
  function automatic logic at_limit(input logic [7:0] v, input logic d);
    return d ? (v == VAL_MAX) : (v == VAL_MIN);
  endfunction

  // Round-robin search: the valid requester with the smallest distance
  // upward from the pointer wins. Returns {hit, index}.
  function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] v, input logic [2:0] p);
    logic [3:0] res;
    int         off;
    int         best;
    res  = 4'd0;
    best = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + N_REQ - int'(p)) % N_REQ;
      if (v[i] && (off < best)) begin
        best = off;
        res  = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  assign pick_s   = rr_pick(req.req_valid, ptr_r);
  assign hit_s    = pick_s[3];
  assign win_s    = pick_s[2:0];
  assign accept_s = (state_r == ST_IDLE) && hit_s;

  // Select the winner's direction and step count.
  always_comb begin
    win_dir_s = 1'b0;
    win_qtd_s = QTD_ZERO;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == win_s) begin
        win_dir_s = req.req_dir[i];
        win_qtd_s = req.req_qtd[i*QTD_W +: QTD_W];
      end else begin
        win_dir_s = win_dir_s;
        win_qtd_s = win_qtd_s;
      end
    end
  end

  // One-hot accept strobe; held low while reset is asserted.
  always_comb begin
    ready_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      ready_s[i] = accept_s && (3'(i) == win_s) && !rst;
    end
  end

  assign req.req_ready = ready_s;

  // Next-state logic. Strobes are computed one cycle ahead so the
  // registered strobe lines up with the cycle in which the step happens.
  always_comb begin
    state_s  = state_r;
    rem_s    = rem_r;
    dir_s    = dir_r;
    sat_s    = sat_r;
    valor_s  = valor_r;
    ptr_s    = ptr_r;
    id_s     = id_r;
    ocup_s   = ocup_r;
    acr_s    = 1'b0;
    dec_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          dir_s  = win_dir_s;
          rem_s  = win_qtd_s;
          id_s   = win_s;
          ptr_s  = (win_s == 3'(N_REQ - 1)) ? 3'd0 : (win_s + 3'd1);
          ocup_s = 1'b1;
          if (win_qtd_s == QTD_ZERO) begin
            state_s = ST_FIM;
          end else begin
            state_s = ST_RUN;
            // Already at the limit: spend the RUN cycle without a strobe.
            if (!at_limit(valor_r, win_dir_s)) begin
              acr_s = win_dir_s;
              dec_s = !win_dir_s;
            end else begin
              acr_s = 1'b0;
              dec_s = 1'b0;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (acr_r || dec_r) begin
          // The counter steps on this edge; keep the shadow in lockstep.
          valor_s = acr_r ? (valor_r + 8'd1) : (valor_r - 8'd1);
          rem_s   = rem_r - QTD_ONE;
          if (rem_s == QTD_ZERO) begin
            state_s = ST_FIM;
          end else if (at_limit(valor_s, dir_r)) begin
            state_s = ST_FIM;
            sat_s   = 1'b1;
          end else begin
            state_s = ST_RUN;
            acr_s   = dir_r;
            dec_s   = !dir_r;
          end
        end else if (rem_r == QTD_ZERO) begin
          state_s = ST_FIM;
        end else begin
          state_s = ST_FIM;
          sat_s   = 1'b1;
        end
      end
      ST_FIM: begin
        state_s = ST_IDLE;
        ocup_s  = 1'b0;
        sat_s   = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        ocup_s  = 1'b0;
        sat_s   = 1'b0;
      end
    endcase
    fim_s    = (state_s == ST_FIM);
    satout_s = (state_s == ST_FIM) ? sat_s : 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rem_r    <= QTD_ZERO;
      dir_r    <= 1'b0;
      sat_r    <= 1'b0;
      valor_r  <= VAL_RESET;
      ptr_r    <= 3'd0;
      id_r     <= 3'd0;
      ocup_r   <= 1'b0;
      acr_r    <= 1'b0;
      dec_r    <= 1'b0;
      fim_r    <= 1'b0;
      satout_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      rem_r    <= rem_s;
      dir_r    <= dir_s;
      sat_r    <= sat_s;
      valor_r  <= valor_s;
      ptr_r    <= ptr_s;
      id_r     <= id_s;
      ocup_r   <= ocup_s;
      acr_r    <= acr_s;
      dec_r    <= dec_s;
      fim_r    <= fim_s;
      satout_r <= satout_s;
    end
  end

  assign acrescer = acr_r;
  assign decrecer = dec_r;
  assign ocupado  = ocup_r;
  assign id_ativo = id_r;
  assign fim      = fim_r;
  assign saturou  = satout_r;
  assign valor    = valor_r;

endmodule

// File: tb/tb_contador_sequenciador.sv
// ----------------------------------------------------------------------------
// tb_contador_sequenciador
// Directed bench: a vector table (inputs + expected outputs per cycle) for
// basic bursts, round-robin order, zero-length and mid-burst input changes,
// followed by hand-written sequences for async reset and saturation.
// ----------------------------------------------------------------------------
module tb_contador_sequenciador;

  logic       clk;
  logic       rst;
  logic       acrescer, decrecer, ocupado, fim, saturou;
  logic [2:0] id_ativo;
  logic [7:0] valor;

  int total;
  int bad;

  contador_sequenciador_if #(.N_REQ(4), .QTD_W(4)) bus ();

  contador_sequenciador #(
    .N_REQ(4), .QTD_W(4), .VAL_RESET(8'h6A), .VAL_MIN(8'h00), .VAL_MAX(8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.slave),
    .acrescer (acrescer),
    .decrecer (decrecer),
    .ocupado  (ocupado),
    .id_ativo (id_ativo),
    .fim      (fim),
    .saturou  (saturou),
    .valor    (valor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  dir;
    logic [15:0] qtd;
    logic [19:0] exp;   // {ready, acr, dec, ocup, id, fim, sat, valor}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] va, input logic [3:0] di,
                              input logic [15:0] q, input logic [3:0] rd, input logic ac,
                              input logic de, input logic oc, input logic [2:0] id,
                              input logic fi, input logic sa, input logic [7:0] vl);
    vec_t t;
    t.rst   = r;
    t.valid = va;
    t.dir   = di;
    t.qtd   = q;
    t.exp   = {rd, ac, de, oc, id, fi, sa, vl};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {bus.req_ready, acrescer, decrecer, ocupado, id_ativo, fim, saturou, valor};
  endfunction

  // Plays one burst on requester idx and checks accept, strobe count,
  // absence of wrong-direction strobes, saturation flag and final value.
  task automatic run_burst(input logic [1:0] idx, input logic d, input logic [3:0] q,
                           input int exp_n, input logic exp_sat, input logic [7:0] exp_val,
                           input string nm);
    int   n_ok;
    int   n_bad;
    logic got;
    logic seen_fim;
    @(negedge clk);
    bus.req_valid                  = 4'h0;
    bus.req_valid[idx]             = 1'b1;
    bus.req_dir[idx]               = d;
    bus.req_qtd[{idx, 2'b00} +: 4] = q;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      #1;
      if (bus.req_ready[idx]) got = 1'b1;
      @(negedge clk);
    end
    bus.req_valid = 4'h0;
    chk({nm, "_accept"}, {31'd0, got}, 32'd1);
    n_ok     = 0;
    n_bad    = 0;
    seen_fim = 1'b0;
    for (int c = 0; c < 40 && !seen_fim; c++) begin
      #1;
      if (fim) begin
        seen_fim = 1'b1;
      end else begin
        if (acrescer && decrecer) n_bad++;
        else if (d ? acrescer : decrecer) n_ok++;
        else if (acrescer || decrecer) n_bad++;
        @(negedge clk);
      end
    end
    chk({nm, "_fim"}, {31'd0, seen_fim}, 32'd1);
    chk({nm, "_strobes"}, n_ok, exp_n);
    chk({nm, "_wrongstrobe"}, n_bad, 32'd0);
    chk({nm, "_sat_valor"}, {23'd0, saturou, valor}, {23'd0, exp_sat, exp_val});
  endtask

  logic [7:0] exp_v;
  int         diff;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid = 4'h0;
    bus.req_dir   = 4'h0;
    bus.req_qtd   = 16'h0000;

    // Reset, with a request present: ready must stay low.
    tbl.push_back(mk(1'b1, 4'h1, 4'h1, 16'h0003, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6A));
    // Requester 0 up by 3.
    tbl.push_back(mk(1'b0, 4'h1, 4'h1, 16'h0003, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6A));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h6A));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h6B));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h6C));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h6D));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6D));
    // Reset again so the round robin starts at 0.
    tbl.push_back(mk(1'b1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6A));
    // All four requesters valid, up by 1: grants 0,1,2,3,0.
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6A));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h6A));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h6B));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6B));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h6B));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h6C));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h4, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'h6C));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h6C));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h6D));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h8, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'h6D));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h6D));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 8'h6E));
    tbl.push_back(mk(1'b0, 4'hF, 4'hF, 16'h1111, 4'h1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 8'h6E));
    tbl.push_back(mk(1'b0, 4'h0, 4'hF, 16'h1111, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h6E));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h6F));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6F));
    // Requester 1 down with qtd=0: straight to fim, no strobes.
    tbl.push_back(mk(1'b0, 4'h2, 4'h0, 16'h0000, 4'h2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6F));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h6F));
    // Requester 2 down by 2, then drops valid and flips dir/qtd mid-burst.
    tbl.push_back(mk(1'b0, 4'h4, 4'h0, 16'h0200, 4'h4, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'h6F));
    tbl.push_back(mk(1'b0, 4'h0, 4'h4, 16'h0F00, 4'h0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h6F));
    tbl.push_back(mk(1'b0, 4'h0, 4'h4, 16'h0F00, 4'h0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h6E));
    tbl.push_back(mk(1'b0, 4'h0, 4'h4, 16'h0F00, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h6D));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'h6D));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst           = tbl[i].rst;
      bus.req_valid = tbl[i].valid;
      bus.req_dir   = tbl[i].dir;
      bus.req_qtd   = tbl[i].qtd;
      #1;
      chk($sformatf("row%0d", i), {12'd0, outs()}, {12'd0, tbl[i].exp});
    end

    // Async reset during the 2nd strobe of a qtd=8 burst.
    @(negedge clk);
    bus.req_valid = 4'h1;
    bus.req_dir   = 4'h1;
    bus.req_qtd   = 16'h0008;
    #1 chk("rs_ready", {28'd0, bus.req_ready}, 32'h1);
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1 chk("rs_strobe1", {22'd0, acrescer, decrecer, valor}, {22'd0, 1'b1, 1'b0, 8'h6D});
    @(negedge clk);
    #1 chk("rs_strobe2", {22'd0, acrescer, decrecer, valor}, {22'd0, 1'b1, 1'b0, 8'h6E});
    bus.req_valid = 4'h2;
    rst = 1'b1;
    #1 chk("rs_async", {12'd0, outs()}, {12'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h6A});
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'h0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rs_nofim", {29'd0, fim, ocupado, acrescer}, 32'd0);
      @(negedge clk);
    end
    // Pointer back at 0: with 0 and 3 valid, 0 must win.
    bus.req_valid = 4'h9;
    bus.req_dir   = 4'h9;
    bus.req_qtd   = 16'h1001;
    #1 chk("rs_ptr0", {28'd0, bus.req_ready}, 32'h1);
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1 chk("rs_run", {20'd0, acrescer, id_ativo, valor}, {20'd0, 1'b1, 3'd0, 8'h6A});
    @(negedge clk);
    #1 chk("rs_fim", {22'd0, fim, saturou, valor}, {22'd0, 1'b1, 1'b0, 8'h6B});

    // Climb to 0xFD with full-count bursts.
    exp_v = 8'h6B;
    while (exp_v != 8'hFD) begin
      diff = int'(8'hFD) - int'(exp_v);
      if (diff > 15) diff = 15;
      run_burst(2'd3, 1'b1, 4'(diff), diff, 1'b0, exp_v + 8'(diff), "climb");
      exp_v = exp_v + 8'(diff);
    end
    // 0xFD up by 5: two strobes, stop at 0xFF, saturated.
    run_burst(2'd1, 1'b1, 4'd5, 2, 1'b1, 8'hFF, "sat_up");
    // Already at 0xFF: no strobe, saturated.
    run_burst(2'd2, 1'b1, 4'd3, 0, 1'b1, 8'hFF, "sat_at");
    // Away from the limit again.
    run_burst(2'd0, 1'b0, 4'd4, 4, 1'b0, 8'hFB, "down");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_sequenciador.md
Name: contador_sequenciador

Overview:
- Shares the 8-bit up/down counter between N_REQ requesters.
- Each requester asks for a burst of N unit steps, up or down. The block picks one requester round-robin and drives the counter's increment/decrement strobes one step per cycle.
- It keeps a shadow copy of the counter value so it can saturate at the limits instead of wrapping.
- It sits directly in front of the counter: its acrescer/decrecer outputs connect to the counter's acrescer/decrecer inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- QTD_W, 4, width of the per-request step count.
- VAL_RESET, 8'h6A, shadow value after reset; must equal the counter's reset value.
- VAL_MIN, 8'h00, lowest value the block will step down to.
- VAL_MAX, 8'hFF, highest value the block will step up to.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_dir  in  N_REQ  step direction per requester: 1 = up, 0 = down.
- req_qtd  in  N_REQ*QTD_W  step count per requester; requester i uses bits [i*QTD_W +: QTD_W].
- req_ready  out  N_REQ  one-hot accept strobe.
- acrescer  out  1  registered increment strobe to the counter.
- decrecer  out  1  registered decrement strobe to the counter.
- ocupado  out  1  high while a burst is in progress.
- id_ativo  out  3  index of the granted requester.
- fim  out  1  one-cycle pulse when a burst ends.
- saturou  out  1  valid with fim; burst was cut short at VAL_MIN or VAL_MAX.
- valor  out  8  shadow of the counter value.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - acrescer, decrecer, ocupado, fim and saturou go to 0; req_ready is 0 while rst is high; id_ativo goes to 0.
  - valor goes to VAL_RESET and the round-robin pointer goes to 0.
  - Any in-flight burst is discarded; its requester gets no fim.
- States: IDLE, RUN, FIM.
- IDLE:
  - req_ready is combinational and asserts only for the round-robin winner: the first i with req_valid[i]=1, searching from the pointer upward and wrapping.
  - Accept happens on the edge where req_valid[i] & req_ready[i] = 1.
  - On accept: latch req_dir[i] and req_qtd[i] into remaining; id_ativo <= i; pointer <= (i+1) mod N_REQ; ocupado <= 1.
  - Next state is RUN, or FIM directly when qtd = 0.
  - req_ready is 0 in every state other than IDLE.
- RUN, each cycle:
  - If remaining = 0: go to FIM, strobes 0.
  - Else if dir = 1 and valor = VAL_MAX, or dir = 0 and valor = VAL_MIN: set the saturation flag, go to FIM, no strobe.
  - Else: drive exactly one of acrescer/decrecer high for this cycle. At the next edge valor steps by ±1 and remaining decrements by 1.
  - acrescer and decrecer are never high together.
- FIM:
  - fim = 1 for one cycle; saturou = the saturation flag.
  - ocupado <= 0 and the saturation flag is cleared.
  - Next state is IDLE.
- Timing:
  - Accept at edge T; strobes are high during cycles T+1 .. T+q; FIM is in cycle T+q+1; the next accept is no earlier than edge T+q+2.
  - A saturated burst enters FIM one cycle after its last strobe.
- valor tracks the counter exactly: both register on the same edge from the same strobe.
- req_valid dropped mid-burst has no effect; the latched request completes.
- req_qtd and req_dir are sampled only at accept.

Test Plan:
- Reset, then req_valid[0]=1, dir=1, qtd=3 → req_ready[0] pulses once; acrescer is high 3 consecutive cycles; valor goes 6A→6B→6C→6D; fim=1 with saturou=0 the next cycle; ocupado drops with it.
- All four requesters valid continuously, each with qtd=1 → grants in order 0,1,2,3,0 with 3 cycles per burst; each req_ready is single-cycle one-hot.
- Set valor to 0xFD via prior bursts, then request up with qtd=5 → 2 acrescer pulses; valor = 0xFF; fim with saturou=1; no wrap to 0x00.
- Request down with qtd=0 → accept, then fim in the next cycle (saturou=0); no strobes; valor unchanged.
- Assert rst during the 2nd strobe of a qtd=8 burst → strobes drop immediately; valor = 0x6A; no fim; pointer = 0; the next request is granted normally.
- Requester 2 drops req_valid mid-burst and changes req_dir → burst still completes its full latched count in the original direction.
